// File: rtl/feature_desc_gen_if.sv
// Pixel-pair input stream and descriptor output stream of feature_desc_gen.
// Both streams use valid/ready: a beat transfers on a rising edge with valid&ready=1,
// and the sender holds its valid and data stable until that transfer happens.
interface feature_desc_gen_if #(
    parameter int PIX_W  = 8,
    parameter int DESC_W = 16
);
    logic              in_valid;
    logic              in_ready;
    logic              in_first;
    logic [PIX_W-1:0]  p_a;
    logic [PIX_W-1:0]  p_b;
    logic              out_valid;
    logic              out_ready;
    logic [DESC_W-1:0] desc;

    modport master (
        output in_valid, in_first, p_a, p_b, out_ready,
        input  in_ready, out_valid, desc
    );

    modport slave (
        input  in_valid, in_first, p_a, p_b, out_ready,
        output in_ready, out_valid, desc
    );
endinterface

// File: rtl/feature_desc_gen.sv
// Packs one (p_a > p_b) bit per accepted pixel pair into a DESC_W-bit binary descriptor.
// Optional FEATURE_DESC_THRESH_EN adds a thresh port: bit = (p_a > p_b + thresh).
module feature_desc_gen #(
    parameter int PIX_W  = 8,
    parameter int DESC_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    feature_desc_gen_if.slave bus,
    output logic [15:0]       desc_cnt,
    output logic              sync_err,
`ifdef FEATURE_DESC_THRESH_EN
    input  logic [PIX_W-1:0]  thresh,
`endif
    output logic              state_dbg
);
    localparam int IDX_W = (DESC_W > 1) ? $clog2(DESC_W) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DESC_W - 1);

    typedef enum logic {COLLECT = 1'b0, HOLD = 1'b1} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [IDX_W-1:0]  idx;
    logic [DESC_W-1:0] desc_q;
    logic              in_ready_c;
    logic              out_valid_c;
    logic              accept;
    logic              resync;
    logic              pair_bit;

    assign accept = bus.in_valid & in_ready_c;
    // in_first in the middle of a descriptor restarts it with this pair as bit 0
    assign resync = accept & bus.in_first & (idx != '0);

`ifdef FEATURE_DESC_THRESH_EN
    assign pair_bit = ({1'b0, bus.p_a} > ({1'b0, bus.p_b} + {1'b0, thresh}));
`else
    assign pair_bit = (bus.p_a > bus.p_b);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= COLLECT;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            COLLECT: if (accept && !resync && idx == IDX_LAST) state_nxt = HOLD;
            HOLD:    if (bus.out_ready) state_nxt = COLLECT;
            default: state_nxt = COLLECT;
        endcase
    end

    always_comb begin
        in_ready_c  = (state == COLLECT);
        out_valid_c = (state == HOLD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx      <= '0;
            desc_q   <= '0;
            desc_cnt <= '0;
            sync_err <= 1'b0;
        end else begin
            sync_err <= resync;
            if (accept) begin
                if (resync) begin
                    desc_q[0] <= pair_bit;
                    idx       <= IDX_W'(1);
                end else begin
                    desc_q[idx] <= pair_bit;
                    idx         <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
                end
            end
            if (out_valid_c && bus.out_ready) desc_cnt <= desc_cnt + 16'd1;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.desc      = desc_q;
    assign state_dbg     = state;
endmodule

// File: tb/tb_feature_desc_gen.sv
// Directed bench for feature_desc_gen: a pair-list model builds expected descriptors,
// compared every cycle; literal expectations pin the model on each directed case.
module tb_feature_desc_gen;
  localparam int PIX_W  = 8;
  localparam int DESC_W = 16;

  logic clk;
  logic rst_n;
  logic [15:0] desc_cnt;
  logic sync_err;
  logic state_dbg;
  logic [PIX_W-1:0] thresh;

  feature_desc_gen_if #(.PIX_W(PIX_W), .DESC_W(DESC_W)) bus ();

  feature_desc_gen #(.PIX_W(PIX_W), .DESC_W(DESC_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .desc_cnt (desc_cnt),
    .sync_err (sync_err),
`ifdef FEATURE_DESC_THRESH_EN
    .thresh   (thresh),
`endif
    .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // model: list of pair results for the descriptor in progress, queue of finished ones
  logic [DESC_W-1:0] exp_q[$];
  logic [DESC_W-1:0] m_bits;
  int                m_n;
  int                m_cnt;
  logic              exp_sync;
  int                n_deliv;
  logic [DESC_W-1:0] last_desc;

  function automatic logic model_bit(input int a, input int b, input int t);
`ifdef FEATURE_DESC_THRESH_EN
    return a > (b + t);
`else
    return a > b;
`endif
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      m_bits   = '0;
      m_n      = 0;
      m_cnt    = 0;
      exp_sync = 1'b0;
    end else begin
      exp_sync = 1'b0;
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) chk("spurious_desc", 32'(bus.desc), 32'hDEAD);
        else chk("desc", 32'(bus.desc), 32'(exp_q.pop_front()));
        last_desc = bus.desc;
        n_deliv++;
        m_cnt = (m_cnt + 1) % 65536;
      end
      if (bus.in_valid && bus.in_ready) begin
        if (bus.in_first && m_n != 0) begin
          m_n      = 0;
          exp_sync = 1'b1;
        end
        m_bits[m_n] = model_bit(int'(bus.p_a), int'(bus.p_b), int'(thresh));
        m_n++;
        if (m_n == DESC_W) begin
          exp_q.push_back(m_bits);
          m_n = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("in_ready",  32'(bus.in_ready),  32'(exp_q.size() == 0));
    chk("out_valid", 32'(bus.out_valid), 32'(exp_q.size() != 0));
    chk("desc_cnt",  32'(desc_cnt),      32'(m_cnt));
    chk("sync_err",  32'(sync_err),      32'(exp_sync));
  end

  // driver tasks: called and returning at a falling edge
  task automatic send(input int a, input int b, input logic first);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.p_a      = PIX_W'(a);
    bus.p_b      = PIX_W'(b);
    bus.in_first = first;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n == 50) chk("accept_timeout", 32'd1, 32'd0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_first = 1'b0;
  endtask

  task automatic wait_delivery();
    int start = n_deliv;
    int k = 0;
    while (n_deliv == start && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("deliver_timeout", 32'(n_deliv != start), 32'd1);
  endtask

  initial begin
    logic [15:0] pat;
    n_deliv       = 0;
    last_desc     = '0;
    rst_n         = 1'b0;
    thresh        = '0;
    bus.in_valid  = 1'b0;
    bus.in_first  = 1'b0;
    bus.p_a       = '0;
    bus.p_b       = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_desc_cnt",  32'(desc_cnt),      32'd0);
    chk("rst_sync_err",  32'(sync_err),      32'd0);
    chk("rst_state",     32'(state_dbg),     32'd0);
    chk("rst_desc",      32'(bus.desc),      32'd0);
    #2 rst_n = 1'b1;
    @(negedge clk);

`ifndef FEATURE_DESC_THRESH_EN
    // 1: alternating pairs, latency of out_valid
    for (int k = 0; k < DESC_W; k++) begin
      if (k % 2 == 0) send(10, 5, k == 0);
      else            send(5, 10, 1'b0);
      if (k == DESC_W - 2) chk("t1_not_yet", 32'(bus.out_valid), 32'd0);
    end
    chk("t1_latency", 32'(bus.out_valid), 32'd1);
    wait_delivery();
    chk("t1_desc", 32'(last_desc), 32'h5555);
    chk("t1_cnt",  32'(desc_cnt),  32'd1);

    // 2: equal pixels, then all-greater
    for (int k = 0; k < DESC_W; k++) send(k * 7, k * 7, k == 0);
    wait_delivery();
    chk("t2_equal", 32'(last_desc), 32'h0000);
    for (int k = 0; k < DESC_W; k++) send(255, 0, k == 0);
    wait_delivery();
    chk("t2_max", 32'(last_desc), 32'hFFFF);
    chk("t2_cnt", 32'(desc_cnt),  32'd3);

    // 3: downstream stall with upstream pushing
    bus.out_ready = 1'b0;
    for (int k = 0; k < DESC_W; k++) send(k < 3 ? 40 : 20, 30, k == 0);
    bus.in_valid = 1'b1;
    bus.in_first = 1'b1;
    bus.p_a      = 8'd200;
    bus.p_b      = 8'd1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t3_stall_ready", 32'(bus.in_ready),  32'd0);
      chk("t3_stall_valid", 32'(bus.out_valid), 32'd1);
      chk("t3_stall_desc",  32'(bus.desc),      32'h0007);
    end
    bus.out_ready = 1'b1;
    send(200, 1, 1'b1);
    chk("t3_held", 32'(last_desc), 32'h0007);
    for (int k = 1; k < DESC_W; k++) send(1, 200, 1'b0);
    wait_delivery();
    chk("t3_next", 32'(last_desc), 32'h0001);
    chk("t3_cnt",  32'(desc_cnt),  32'd5);

    // 4: in_first mid-descriptor resynchronises
    for (int k = 0; k < 7; k++) send(3, 1, k == 0);
    send(9, 1, 1'b1);
    chk("t4_sync_pulse", 32'(sync_err), 32'd1);
    for (int k = 0; k < DESC_W - 1; k++) send(0, 1, 1'b0);
    chk("t4_sync_gone", 32'(sync_err), 32'd0);
    wait_delivery();
    chk("t4_desc", 32'(last_desc), 32'h0001);
    chk("t4_cnt",  32'(desc_cnt),  32'd6);

    // 5: asynchronous reset mid-descriptor
    for (int k = 0; k < 10; k++) send(50, 10, k == 0);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("t5_rst_ready", 32'(bus.in_ready),  32'd1);
    chk("t5_rst_cnt",   32'(desc_cnt),      32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    pat = 16'hC3A5;
    for (int k = 0; k < DESC_W; k++) send(pat[k] ? 20 : 10, 15, k == 0);
    wait_delivery();
    chk("t5_desc", 32'(last_desc), 32'hC3A5);
    chk("t5_cnt",  32'(desc_cnt),  32'd1);
`else
    // 6: threshold margin
    thresh = 8'd4;
    for (int k = 0; k < DESC_W; k++) begin
      if (k % 2 == 0) send(14, 10, k == 0);
      else            send(15, 10, 1'b0);
    end
    wait_delivery();
    chk("t6_thresh4", 32'(last_desc), 32'hAAAA);
    thresh = 8'd255;
    for (int k = 0; k < DESC_W; k++) send(255, 255, k == 0);
    wait_delivery();
    chk("t6_thresh255", 32'(last_desc), 32'h0000);
    thresh = 8'd0;
    for (int k = 0; k < DESC_W; k++) send(k < 8 ? 9 : 1, 5, k == 0);
    wait_delivery();
    chk("t6_thresh0", 32'(last_desc), 32'h00FF);
    chk("t6_cnt", 32'(desc_cnt), 32'd3);
`endif

    repeat (3) @(negedge clk);
    chk("end_idle", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
